regfile_spiller: RTL

//  Block-transfer engine on the regfile port pair. Spill: streams cmd_count words read from the regfile out on a

---
 rtl/regfile_spiller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_spiller.sv
// Block-transfer engine between a regfile port pair and valid/ready streams:
// spill copies regfile words out through a 2-entry FIFO, fill writes incoming words into the regfile.
module regfile_spiller #(
    parameter int D = 8,
    parameter int W = 64
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_fill,
    input  logic [D:0]     cmd_base,
    input  logic [D+1:0]   cmd_count,
    output logic           busy,
    output logic           done,
    output logic           rf_rden,
    output logic [D:0]     rf_rdaddress,
    input  logic [W-1:0]   rf_q,
    output logic           rf_wren,
    output logic [D:0]     rf_wraddress,
    output logic [W-1:0]   rf_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic [1:0]     state_dbg
);

    // Handshakes: a word moves on out (or in) at the rising edge where valid and ready are both 1;
    // valid never depends on ready, and a command is taken on the edge where cmd_valid and cmd_ready are both 1.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [D+1:0] MAX_COUNT = {1'b1, {(D+1){1'b0}}};

    state_t         state_q, state_d;
    logic [D:0]     ptr_q, ptr_d;
    logic [D+1:0]   rem_q, rem_d;
    logic [D+1:0]   acc_rem_q, acc_rem_d;
    logic           inflight_q, inflight_d;
    logic [W-1:0]   mem0_q, mem0_d;
    logic [W-1:0]   mem1_q, mem1_d;
    logic           rd_idx_q, rd_idx_d;
    logic           wr_idx_q, wr_idx_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           rf_wren_q, rf_wren_d;
    logic [D:0]     rf_wraddress_q, rf_wraddress_d;
    logic [W-1:0]   rf_data_q, rf_data_d;

    logic [D+1:0]   clamped;
    logic           out_valid_c;
    logic           out_fire;
    logic           in_ready_c;
    logic           in_fire;
    logic [2:0]     pending;
    logic           rd_issue;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        rem_d          = rem_q;
        acc_rem_d      = acc_rem_q;
        inflight_d     = 1'b0;
        mem0_d         = mem0_q;
        mem1_d         = mem1_q;
        rd_idx_d       = rd_idx_q;
        wr_idx_d       = wr_idx_q;
        cnt_d          = cnt_q;
        rf_wren_d      = 1'b0;
        rf_wraddress_d = rf_wraddress_q;
        rf_data_d      = rf_data_q;

        clamped     = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
        out_valid_c = (state_q == SPILL) && (cnt_q != 2'd0);
        out_fire    = out_valid_c && out_ready;
        in_ready_c  = (state_q == FILL) && (rem_q != '0);
        in_fire     = in_ready_c && in_valid;

        // Occupancy after this cycle's pop plus the read already in flight; counting the pop
        // lets a new read issue while a word leaves, so a ready consumer sees no bubbles.
        pending  = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, out_fire};
        rd_issue = (state_q == SPILL) && (rem_q != '0) && (pending < 3'd2);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_d     = cmd_base;
                    rem_d     = clamped;
                    acc_rem_d = clamped;
                    if (clamped == '0) begin
                        state_d = DONE;
                    end else if (cmd_fill) begin
                        state_d = FILL;
                    end else begin
                        state_d = SPILL;
                    end
                end
            end
            SPILL: begin
                if (rd_issue) begin
                    inflight_d = 1'b1;
                    ptr_d      = ptr_q + (D+1)'(1);
                    rem_d      = rem_q - (D+2)'(1);
                end
                if (out_fire) begin
                    acc_rem_d = acc_rem_q - (D+2)'(1);
                    if (acc_rem_q == (D+2)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                if (in_fire) begin
                    rf_wren_d      = 1'b1;
                    rf_wraddress_d = ptr_q;
                    rf_data_d      = in_data;
                    ptr_d          = ptr_q + (D+1)'(1);
                    rem_d          = rem_q - (D+2)'(1);
                    if (rem_q == (D+2)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // rf_q carries the word read in the previous cycle
        if (inflight_q) begin
            if (wr_idx_q) begin
                mem1_d = rf_q;
            end else begin
                mem0_d = rf_q;
            end
            wr_idx_d = ~wr_idx_q;
        end
        if (out_fire) begin
            rd_idx_d = ~rd_idx_q;
        end
        cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, out_fire};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            rem_q          <= '0;
            acc_rem_q      <= '0;
            inflight_q     <= 1'b0;
            mem0_q         <= '0;
            mem1_q         <= '0;
            rd_idx_q       <= 1'b0;
            wr_idx_q       <= 1'b0;
            cnt_q          <= 2'd0;
            rf_wren_q      <= 1'b0;
            rf_wraddress_q <= '0;
            rf_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            rem_q          <= rem_d;
            acc_rem_q      <= acc_rem_d;
            inflight_q     <= inflight_d;
            mem0_q         <= mem0_d;
            mem1_q         <= mem1_d;
            rd_idx_q       <= rd_idx_d;
            wr_idx_q       <= wr_idx_d;
            cnt_q          <= cnt_d;
            rf_wren_q      <= rf_wren_d;
            rf_wraddress_q <= rf_wraddress_d;
            rf_data_q      <= rf_data_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign rf_rden      = rd_issue;
    assign rf_rdaddress = ptr_q;
    assign rf_wren      = rf_wren_q;
    assign rf_wraddress = rf_wraddress_q;
    assign rf_data      = rf_data_q;
    assign out_valid    = out_valid_c;
    assign out_data     = rd_idx_q ? mem1_q : mem0_q;
    assign in_ready     = in_ready_c;
    assign state_dbg    = state_q;

endmodule
